// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU definitions: sequencer state encoding and counter sizing
//
// Purpose:
//   Common types and helpers for the ALU serial units.
// Contents:
//   state_t    : serial-unit FSM encoding (S_IDLE=0, S_RUN=1, S_DONE=2)
//   cnt_width(): bit-counter width for a given operand width, $clog2(WIDTH)

package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  // Clamped to one bit so a degenerate width still gives a legal vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
//
// Purpose:
//   Single bit of a - b - bi with borrow-out, plus borrow propagate/generate
//   terms for a future lookahead-borrow variant.
// Ports:
//   inA  in  1  minuend bit
//   inB  in  1  subtrahend bit
//   bin  in  1  borrow-in
//   diff out 1  difference bit
//   bout out 1  borrow-out
//   p    out 1  borrow propagate, ~(a^b)
//   g    out 1  borrow generate, ~a & b

module full_subtractor (
  input  logic inA,
  input  logic inB,
  input  logic bin,
  output logic diff,
  output logic bout,
  output logic p,
  output logic g
);

  logic w_x;

  assign w_x  = inA ^ inB;
  assign diff = w_x ^ bin;
  assign p    = ~w_x;
  assign g    = ~inA & inB;
  assign bout = g | (p & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, diff = inA - inB - bin
//
// Purpose:
//   Area-cheap subtract/compare unit for the ALU sequencer. One full-subtractor
//   cell is reused for WIDTH cycles; a start/busy/done handshake frames each op.
//   Start accepted at edge N gives done in cycle N+WIDTH+1; one op per WIDTH+1.
// Configuration:
//   SUB_FLAGS_EN : when defined, adds zero/neg/ovf status outputs.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   start in  1      request, sampled when busy=0 and in the done cycle
//   inA   in  WIDTH  minuend, captured on accepted start
//   inB   in  WIDTH  subtrahend, captured on accepted start
//   bin   in  1      borrow-in, captured on accepted start
//   busy  out 1      operation in progress (RUN or DONE)
//   done  out 1      one-cycle pulse, diff/bout valid from this cycle on
//   diff  out WIDTH  result, held until the next result
//   bout  out 1      final borrow-out (unsigned inA < inB+bin)
//   zero  out 1      diff == 0                    (SUB_FLAGS_EN only)
//   neg   out 1      diff MSB                     (SUB_FLAGS_EN only)
//   ovf   out 1      signed overflow of inA - inB (SUB_FLAGS_EN only)

module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  // Holds the WIDTH-1 result bits produced so far; the final bit comes
  // straight from the cell on the last RUN cycle.
  logic [WIDTH-2:0] r_sh_r;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_load;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_d;
  logic             w_bo;
  logic             w_p;
  logic             w_g;
  logic [WIDTH-1:0] w_res;

  full_subtractor u_cell (
    .inA  (r_sh_a[0]),
    .inB  (r_sh_b[0]),
    .bin  (r_brw),
    .diff (w_d),
    .bout (w_bo),
    .p    (w_p),
    .g    (w_g)
  );

  // Propagate/generate are reserved for a lookahead variant.
  logic w_unused_pg;
  assign w_unused_pg = w_p ^ w_g;

  assign w_res  = {w_d, r_sh_r};
  assign w_last = (r_state == S_RUN) && (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        // Back-to-back: a start in the done cycle is accepted immediately.
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef SUB_FLAGS_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_zero;
  logic r_neg;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_msb <= inA[WIDTH-1];
        r_b_msb <= inB[WIDTH-1];
      end
      if (w_last) begin
        r_zero <= (w_res == '0);
        r_neg  <= w_d;
        r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_r  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_sh_a <= inA;
        r_sh_b <= inB;
        r_brw  <= bin;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_sh_a <= r_sh_a >> 1;
        r_sh_b <= r_sh_b >> 1;
        r_sh_r <= w_res[WIDTH-1:1];
        r_brw  <= w_bo;
        r_cnt  <= r_cnt + 1'b1;
      end
      // Results are captured on entry to DONE so they are valid while done is high.
      if (w_last) begin
        r_diff <= w_res;
        r_bout <= w_bo;
      end
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
